// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: fetch-stage sequencer for PC enable, IF/ID enable/flush/valid, halt and miss timeout.
// Optional perf counters are compiled in with FETCH_STALL_PERF_EN.
module fetch_stall_ctrl #(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic imem_stall,
  input  logic imem_done,
  input  logic dmem_stall,
  input  logic load_use,
  input  logic redirect,
  input  logic halt_dec,
  output logic pc_en,
  output logic if_id_en,
  output logic if_id_flush,
  output logic if_id_valid,
  output logic halted,
  output logic miss_err
`ifdef FETCH_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_miss_cyc,
  output logic [CNT_W-1:0] perf_hazard_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, SQUASH = 2'd2, HALTED = 2'd3} state_t;
  localparam logic [7:0] TMO = 8'(MISS_TIMEOUT);
  state_t state_q, state_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic miss_err_q, miss_err_d;
  logic in_miss;
  always_comb begin
    state_d = state_q;
    pc_en = 1'b0;
    if_id_en = 1'b0;
    if_id_flush = 1'b0;
    if_id_valid = 1'b0;
    halted = state_q == HALTED;
    if (rst) begin
      if_id_en = 1'b1;
      if_id_flush = 1'b1;
      halted = 1'b0;
    end else if (state_q != HALTED && !dmem_stall) begin
      if (redirect) begin
        pc_en = 1'b1;
        if_id_en = 1'b1;
        if_id_flush = 1'b1;
        // a wrong-path fetch still outstanding must be swallowed in SQUASH
        state_d = state_q == RUN ? (imem_stall ? SQUASH : RUN) : (imem_done ? RUN : SQUASH);
      end else if (state_q == RUN && halt_dec) begin
        state_d = HALTED;
      end else if (load_use) begin
        state_d = state_q;
      end else if (state_q == RUN) begin
        if_id_en = 1'b1;
        if_id_flush = imem_stall;
        if_id_valid = !imem_stall;
        pc_en = !imem_stall;
        state_d = imem_stall ? IMISS : RUN;
      end else begin
        if_id_en = 1'b1;
        if_id_flush = !(state_q == IMISS && imem_done);
        if_id_valid = !if_id_flush;
        pc_en = if_id_valid;
        state_d = imem_done ? RUN : state_q;
      end
    end
    in_miss = state_q == IMISS || state_q == SQUASH;
    miss_cnt_d = in_miss ? miss_cnt_q + {7'd0, miss_cnt_q != 8'hff} : 8'd0;
    miss_err_d = miss_err_q | (in_miss && miss_cnt_d >= TMO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      miss_cnt_q <= 8'd0;
      miss_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_cnt_q <= miss_cnt_d;
      miss_err_q <= miss_err_d;
    end
  end
  assign miss_err = miss_err_q;
`ifdef FETCH_STALL_PERF_EN
  logic [CNT_W-1:0] perf_miss_cyc_q, perf_miss_cyc_d;
  logic [CNT_W-1:0] perf_hazard_cyc_q, perf_hazard_cyc_d;
  logic [CNT_W-1:0] perf_flush_cnt_q, perf_flush_cnt_d;
  logic live, redir_take, lu_stall;
  always_comb begin
    live = state_q != HALTED && !dmem_stall;
    redir_take = live && redirect;
    lu_stall = live && !redirect && !(state_q == RUN && halt_dec) && load_use;
    perf_miss_cyc_d = perf_miss_cyc_q + CNT_W'(in_miss && !(&perf_miss_cyc_q));
    perf_hazard_cyc_d = perf_hazard_cyc_q + CNT_W'(lu_stall && !(&perf_hazard_cyc_q));
    perf_flush_cnt_d = perf_flush_cnt_q + CNT_W'(redir_take && !(&perf_flush_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cyc_q <= '0;
      perf_hazard_cyc_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_miss_cyc_q <= perf_miss_cyc_d;
      perf_hazard_cyc_q <= perf_hazard_cyc_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end
  assign perf_miss_cyc = perf_miss_cyc_q;
  assign perf_hazard_cyc = perf_hazard_cyc_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: directed and random stimulus against a fetch-pending/wrong-path reference model.
module tb_fetch_stall_ctrl;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst, imem_stall, imem_done, dmem_stall, load_use, redirect, halt_dec;
  logic pc_en, if_id_en, if_id_flush, if_id_valid, halted, miss_err;
`ifdef FETCH_STALL_PERF_EN
  logic [15:0] perf_miss_cyc, perf_hazard_cyc, perf_flush_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;
  bit pend = 0, wrong = 0, hlt = 0, err = 0;
  int miss_run = 0;
  always #5 clk = ~clk;
  fetch_stall_ctrl #(.MISS_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .imem_done(imem_done),
    .dmem_stall(dmem_stall), .load_use(load_use), .redirect(redirect), .halt_dec(halt_dec),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .if_id_valid(if_id_valid),
    .halted(halted), .miss_err(miss_err)
`ifdef FETCH_STALL_PERF_EN
    , .perf_miss_cyc(perf_miss_cyc), .perf_hazard_cyc(perf_hazard_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit is, input bit id, input bit ds, input bit lu, input bit rd, input bit hd);
    logic [4:0] o;
    {rst, imem_stall, imem_done, dmem_stall, load_use, redirect, halt_dec} = {r, is, id, ds, lu, rd, hd};
    @(negedge clk);
    if (r) o = 5'b01100;
    else if (hlt) o = 5'b00001;
    else if (ds) o = 5'b00000;
    else if (rd) o = 5'b11100;
    else if (!pend && hd) o = 5'b00000;
    else if (lu) o = 5'b00000;
    else if (!pend) o = is ? 5'b01100 : 5'b11010;
    else if (id && !wrong) o = 5'b11010;
    else o = 5'b01100;
    chk("pc_en/en/flush/valid/halted/err", {26'd0, pc_en, if_id_en, if_id_flush, if_id_valid, halted, miss_err}, {26'd0, o, err});
    chk("valid_invariant", {31'd0, if_id_valid & (if_id_flush | ~if_id_en)}, 32'd0);
    if (r) begin
      pend = 0; wrong = 0; hlt = 0; err = 0; miss_run = 0;
    end else if (!hlt) begin
      miss_run = pend ? miss_run + 1 : 0;
      if (miss_run >= TMO) err = 1;
      if (!ds) begin
        if (rd) begin
          if (!pend) begin pend = is; wrong = is; end
          else if (id) begin pend = 0; wrong = 0; end
          else wrong = 1;
        end else if (!pend && hd) hlt = 1;
        else if (lu) begin end
        else if (!pend) begin pend = is; wrong = 0; end
        else if (id) begin pend = 0; wrong = 0; end
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, i % 3 == 0, 0, 0, i % 5 == 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 40, $urandom_range(99) < 25,
          $urandom_range(99) < 10, $urandom_range(99) < 10, $urandom_range(99) < 10,
          $urandom_range(99) < 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
